// File: rtl/adc_conv_sequencer_if.sv
// ADC conversion port and result-FIFO read port of the conversion sequencer.
// master = sequencer side, slave = ADC / FIFO consumer side.
interface adc_conv_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          adc_start_out;
  logic [15:0]   adc_config_1_out;
  logic [15:0]   adc_config_2_out;
  logic [15:0]   adc_result_in;
  logic          adc_finished_in;
  logic [15:0]   data_out;
  logic          data_valid_out;
  logic          data_ready_in;
  logic [LW-1:0] fifo_level_out;

  modport master (
    output adc_start_out, adc_config_1_out, adc_config_2_out,
           data_out, data_valid_out, fifo_level_out,
    input  adc_result_in, adc_finished_in, data_ready_in
  );

  modport slave (
    input  adc_start_out, adc_config_1_out, adc_config_2_out,
           data_out, data_valid_out, fifo_level_out,
    output adc_result_in, adc_finished_in, data_ready_in
  );
endinterface

// File: rtl/adc_conv_sequencer.sv
// Host-side SAR-ADC sequencer: periodic/single-shot conversion issue, async finish
// synchronisation, timeout abort and a small valid/ready result FIFO.
module adc_conv_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_in,
  input  logic                 single_in,
  input  logic                 clear_in,
  input  logic [15:0]          period_in,
  input  logic [15:0]          config_1_in,
  input  logic [15:0]          config_2_in,
  adc_conv_sequencer_if.master bus,
  output logic                 busy_out,
  output logic                 overrun_out,
  output logic                 timeout_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_e;
  typedef struct packed {
    logic [15:0] cfg1;
    logic [15:0] cfg2;
  } cfg_t;

  logic                           fin_meta_q, fin_s_q, fin_s_d_q, fin_rise;
  logic                           en_prev_q, trig_per, trigger, take;
  logic [15:0]                    per_cnt_q, per_cnt_d;
  logic                           pending_q, pending_d;
  state_e                         state_q, state_d;
  logic                           start_q, start_d, busy_q, busy_d;
  logic [SW-1:0]                  st_cnt_q, st_cnt_d;
  logic [TW-1:0]                  tmo_cnt_q, tmo_cnt_d;
  logic                           tmo_hit, tmo_evt, push;
  logic                           fin_seen_q, fin_seen_d;
  cfg_t                           cfg_q, cfg_d;
  logic [FIFO_DEPTH-1:0][15:0]    mem_q, mem_d;
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                  level_q, level_d;
  logic                           pop, full, push_ok, ovr_evt;
  logic                           ovr_q, ovr_d, tmo_q, tmo_d;

  assign fin_rise = fin_s_q & ~fin_s_d_q;

  // Down-counter trigger; enable rising preloads 0 so the first trigger is next cycle.
  always_comb begin
    per_cnt_d = per_cnt_q;
    trig_per  = 1'b0;
    if (enable_in) begin
      if (!en_prev_q)               per_cnt_d = '0;
      else if (per_cnt_q == 16'd0) begin
        trig_per  = 1'b1;
        per_cnt_d = period_in;
      end else                      per_cnt_d = per_cnt_q - 16'd1;
    end
  end

  assign trigger   = trig_per | single_in;
  assign pending_d = (pending_q & ~take) | trigger;
  assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    st_cnt_d   = st_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    fin_seen_d = fin_seen_q;
    cfg_d      = cfg_q;
    take       = 1'b0;
    push       = 1'b0;
    tmo_evt    = 1'b0;
    case (state_q)
      IDLE: if (pending_q) begin
        take       = 1'b1;
        cfg_d      = '{cfg1: config_1_in, cfg2: config_2_in};
        state_d    = START;
        start_d    = 1'b1;
        st_cnt_d   = '0;
        tmo_cnt_d  = '0;
        fin_seen_d = 1'b0;
      end
      START: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        // A finish seen this early is held until WAIT is entered.
        if (fin_rise) fin_seen_d = 1'b1;
        if (tmo_hit) begin
          state_d = IDLE;
          start_d = 1'b0;
          tmo_evt = 1'b1;
        end else if (st_cnt_q == SW'(START_CYCLES - 1)) begin
          state_d = WAIT;
          start_d = 1'b0;
        end else st_cnt_d = st_cnt_q + SW'(1);
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (fin_rise || fin_seen_q) state_d = CAPTURE;
        else if (tmo_hit) begin
          state_d = IDLE;
          tmo_evt = 1'b1;
        end
      end
      CAPTURE: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  // FIFO: a push while full is only accepted when the head leaves in the same cycle.
  always_comb begin
    pop      = (level_q != '0) & bus.data_ready_in;
    full     = (level_q == LW'(FIFO_DEPTH));
    push_ok  = push & (~full | pop);
    ovr_evt  = push & full & ~pop;
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = bus.adc_result_in;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push_ok) - LW'(pop);
    ovr_d    = ovr_evt | (ovr_q & ~clear_in);
    tmo_d    = tmo_evt | (tmo_q & ~clear_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_meta_q <= 1'b0;
      fin_s_q    <= 1'b0;
      fin_s_d_q  <= 1'b0;
      en_prev_q  <= 1'b0;
      per_cnt_q  <= '0;
      pending_q  <= 1'b0;
      state_q    <= IDLE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      st_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
      fin_seen_q <= 1'b0;
      cfg_q      <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      fin_meta_q <= bus.adc_finished_in;
      fin_s_q    <= fin_meta_q;
      fin_s_d_q  <= fin_s_q;
      en_prev_q  <= enable_in;
      per_cnt_q  <= per_cnt_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      st_cnt_q   <= st_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      fin_seen_q <= fin_seen_d;
      cfg_q      <= cfg_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.adc_start_out    = start_q;
  assign bus.adc_config_1_out = cfg_q.cfg1;
  assign bus.adc_config_2_out = cfg_q.cfg2;
  assign bus.data_out         = mem_q[rd_ptr_q];
  assign bus.data_valid_out   = (level_q != '0);
  assign bus.fifo_level_out   = level_q;
  assign busy_out             = busy_q;
  assign overrun_out          = ovr_q;
  assign timeout_out          = tmo_q;
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed + randomized bench for adc_conv_sequencer with a behavioural ADC and
// an in-order result scoreboard.
`timescale 1ns/1ps
module tb_adc_conv_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 4096;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable_in = 1'b0, single_in = 1'b0, clear_in = 1'b0;
  logic [15:0] period_in = '0, config_1_in = '0, config_2_in = '0;
  logic        busy_out, overrun_out, timeout_out;

  adc_conv_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  adc_conv_sequencer #(.FIFO_DEPTH(DEPTH), .START_CYCLES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .single_in(single_in),
    .clear_in(clear_in), .period_in(period_in), .config_1_in(config_1_in),
    .config_2_in(config_2_in), .bus(bus), .busy_out(busy_out),
    .overrun_out(overrun_out), .timeout_out(timeout_out)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          cyc = 0, pops = 0;
  int          starts_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] res_plan[$];
  logic        tb_start_prev = 1'b0;

  // Behavioural ADC: finished drops on start, rises adc_lat cycles later with a result.
  int          adc_lat = 10;
  bit          adc_never = 1'b0, adc_kill = 1'b0;
  int          adc_timer = 0;
  logic        m_start_prev = 1'b0;
  logic [15:0] m_res;

  initial begin
    bus.adc_finished_in = 1'b0;
    bus.adc_result_in   = '0;
    forever begin
      @(negedge clk);
      if (adc_kill) adc_timer = 0;
      else if (bus.adc_start_out && !m_start_prev) begin
        bus.adc_finished_in = 1'b0;
        adc_timer = adc_lat;
      end else if (adc_timer > 0) begin
        adc_timer--;
        if (adc_timer == 0 && !adc_never) begin
          m_res = (res_plan.size() != 0) ? res_plan.pop_front() : 16'($urandom);
          bus.adc_result_in   = m_res;
          bus.adc_finished_in = 1'b1;
          exp_q.push_back(m_res);
        end
      end
      m_start_prev = bus.adc_start_out;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 5 ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A pop is decided by what is driven now, before the coming edge.
  task automatic tick();
    if (bus.data_valid_out && bus.data_ready_in) begin
      pops++;
      chk("pop_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("pop_data", bus.data_out, exp_q.pop_front());
    end
    @(negedge clk); #1;
    cyc++;
    if (bus.adc_start_out && !tb_start_prev) starts_q.push_back(cyc);
    tb_start_prev = bus.adc_start_out;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy_out && k < TMO + 100) begin tick(); k++; end
    chk(tag, busy_out, 0);
  endtask

  task automatic pulse_single();
    single_in = 1'b1; tick(); single_in = 1'b0;
  endtask

  task automatic run_single(input string tag);
    pulse_single(); tick(); tick();
    wait_idle(tag);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    bus.data_ready_in = 1'b1;
    while (bus.data_valid_out && k < 20) begin tick(); k++; end
    bus.data_ready_in = 1'b0;
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"}, bus.adc_start_out, 0);
    chk({tag, "_cfg1"},  bus.adc_config_1_out, 0);
    chk({tag, "_cfg2"},  bus.adc_config_2_out, 0);
    chk({tag, "_data"},  bus.data_out, 0);
    chk({tag, "_valid"}, bus.data_valid_out, 0);
    chk({tag, "_level"}, bus.fifo_level_out, 0);
    chk({tag, "_busy"},  busy_out, 0);
    chk({tag, "_ovr"},   overrun_out, 0);
    chk({tag, "_tmo"},   timeout_out, 0);
  endtask

  initial begin
    int k, s0, lat_fv, per;
    bus.data_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    tick(); tick();

    // Single shot: start timing, width, finish-to-valid latency.
    res_plan.push_back(16'h0ABC); adc_lat = 40;
    pulse_single();
    k = 1;
    while (!bus.adc_start_out && k < 10) begin tick(); k++; end
    chk("t1_trig_to_start", k, 2);
    k = 0;
    while (bus.adc_start_out && k < 20) begin k++; tick(); end
    chk("t1_start_width", k, 2);
    k = 0;
    while (!bus.adc_finished_in && k < 100) begin tick(); k++; end
    chk("t1_fin_seen", bus.adc_finished_in, 1);
    k = 0;
    while (!bus.data_valid_out && k < 20) begin tick(); k++; end
    lat_fv = k;
    chk("t1_fin_to_valid_le5", 32'(lat_fv >= 1 && lat_fv <= 5), 1);
    chk("t1_data", bus.data_out, 16'h0ABC);
    chk("t1_level", bus.fifo_level_out, 1);
    wait_idle("t1_idle");
    drain("t1_drain");
    chk("t1_level_empty", bus.fifo_level_out, 0);

    // Periodic, period_in=99: starts 100 cycles apart, popped in order.
    period_in = 16'd99; adc_lat = 30; bus.data_ready_in = 1'b1;
    starts_q.delete(); pops = 0;
    enable_in = 1'b1;
    k = 0;
    while (starts_q.size() < 4 && k < 1000) begin tick(); k++; end
    enable_in = 1'b0;
    chk("t2_starts", starts_q.size(), 4);
    if (starts_q.size() >= 4)
      for (int i = 1; i < 4; i++) chk("t2_interval", starts_q[i] - starts_q[i-1], 100);
    k = 0;
    while ((busy_out || exp_q.size() != 0) && k < 300) begin tick(); k++; end
    bus.data_ready_in = 1'b0;
    chk("t2_pops", pops, 4);
    chk("t2_no_overrun", overrun_out, 0);

    // Back-to-back with no reader: only DEPTH results fit, the rest are dropped.
    period_in = 16'd0; adc_lat = 10; starts_q.delete();
    for (int i = 1; i <= 5; i++) res_plan.push_back(16'(i));
    enable_in = 1'b1;
    k = 0;
    while (starts_q.size() < 4 && k < 500) begin tick(); k++; end
    enable_in = 1'b0;
    repeat (150) tick();
    chk("t3_starts", starts_q.size(), 5);
    chk("t3_level", bus.fifo_level_out, DEPTH);
    chk("t3_overrun", overrun_out, 1);
    chk("t3_results", exp_q.size(), 5);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    clear_in = 1'b1; tick(); clear_in = 1'b0;
    chk("t3_overrun_clr", overrun_out, 0);
    drain("t3_drain");

    // Timeout: finish never arrives.
    adc_never = 1'b1;
    pulse_single();
    k = 0;
    while (!bus.adc_start_out && k < 10) begin tick(); k++; end
    s0 = cyc;
    k = 0;
    while (!timeout_out && k < TMO + 100) begin tick(); k++; end
    chk("t4_timeout", timeout_out, 1);
    chk("t4_cycles", cyc - s0, TMO);
    chk("t4_busy", busy_out, 0);
    chk("t4_level", bus.fifo_level_out, 0);
    adc_never = 1'b0;
    repeat (5) tick();
    chk("t4_sticky", timeout_out, 1);
    clear_in = 1'b1; tick(); clear_in = 1'b0;
    chk("t4_clr", timeout_out, 0);
    run_single("t4_retry_idle");
    chk("t4_retry_level", bus.fifo_level_out, 1);
    drain("t4_drain");

    // Config held stable through a conversion.
    config_1_in = 16'h0001; config_2_in = 16'h5A5A; adc_lat = 40;
    pulse_single(); tick();
    chk("t5_cfg1_start", bus.adc_config_1_out, 16'h0001);
    chk("t5_cfg2_start", bus.adc_config_2_out, 16'h5A5A);
    config_1_in = 16'h0007;
    repeat (10) tick();
    chk("t5_cfg1_mid", bus.adc_config_1_out, 16'h0001);
    wait_idle("t5_idle");
    chk("t5_cfg1_after", bus.adc_config_1_out, 16'h0001);
    pulse_single(); tick();
    chk("t5_cfg1_next", bus.adc_config_1_out, 16'h0007);
    wait_idle("t5_idle2");
    drain("t5_drain");

    // Random period/latency/reader stall.
    per = $urandom_range(60, 25);
    period_in = 16'(per); adc_lat = $urandom_range(15, 8);
    starts_q.delete(); pops = 0;
    enable_in = 1'b1;
    repeat (400) begin
      bus.data_ready_in = ($urandom_range(3, 0) != 0);
      tick();
    end
    enable_in = 1'b0;
    bus.data_ready_in = 1'b1;
    wait_idle("t6_idle");
    drain("t6_drain");
    chk("t6_pops", pops, starts_q.size());
    for (int i = 1; i < starts_q.size(); i++)
      chk("t6_interval", starts_q[i] - starts_q[i-1], per + 1);
    chk("t6_no_overrun", overrun_out, 0);

    // Full FIFO with a pop in the capture cycle: accepted, no overrun.
    adc_lat = 10;
    for (int i = 0; i < DEPTH; i++) run_single("t7_fill");
    chk("t7_full", bus.fifo_level_out, DEPTH);
    pulse_single();
    k = 0;
    while (bus.adc_finished_in && k < 10) begin tick(); k++; end
    k = 0;
    while (!bus.adc_finished_in && k < 100) begin tick(); k++; end
    repeat (lat_fv - 1) tick();
    bus.data_ready_in = 1'b1; tick(); bus.data_ready_in = 1'b0;
    chk("t7_level", bus.fifo_level_out, DEPTH);
    chk("t7_no_overrun", overrun_out, 0);
    chk("t7_pending", exp_q.size(), DEPTH);
    drain("t7_drain");

    // Reset during WAIT with a non-empty FIFO, then during START.
    run_single("t8_pre");
    config_1_in = 16'h1234; adc_lat = 40;
    pulse_single();
    k = 0;
    while (!bus.adc_start_out && k < 10) begin tick(); k++; end
    while (bus.adc_start_out && k < 20) begin tick(); k++; end
    repeat (3) tick();
    chk("t8_pre_busy", busy_out, 1);
    rst_n = 1'b0; #1;
    check_all_zero("t8_wait_rst");
    tick(); rst_n = 1'b1;
    adc_kill = 1'b1; repeat (60) tick(); adc_kill = 1'b0;
    exp_q.delete(); res_plan.delete();
    pulse_single();
    k = 0;
    while (!bus.adc_start_out && k < 10) begin tick(); k++; end
    chk("t8_start_hi", bus.adc_start_out, 1);
    rst_n = 1'b0; #1;
    chk("t8_start_rst", bus.adc_start_out, 0);
    chk("t8_start_rst_busy", busy_out, 0);
    tick(); rst_n = 1'b1;
    adc_kill = 1'b1; repeat (60) tick(); adc_kill = 1'b0;
    exp_q.delete();
    run_single("t8_recover");
    chk("t8_recover_level", bus.fifo_level_out, 1);
    drain("t8_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
